// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, FSM states, datapath width.
package exec_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_AND  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SLL  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_SLT  = 5'b01000,
        ALU_SLTU = 5'b01001,
        ALU_MUL  = 5'b01010
    } alu_op_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } exec_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits, one partial product per step.
module mul_iter
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [4:0]      cnt,
    output logic [XLEN-1:0] product
);

    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_q;
    logic [4:0]      cnt_q;

    // product already includes the current step, so the final step's value is usable at its own edge
    assign product = acc_q + (b_q[0] ? a_q : '0);
    assign cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step) begin
            acc_q <= product;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU plus a 33-edge iterative multiply with stall, flush and EX/MEM register.
module execute_stage
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [4:0]      alu_control,
    input  logic            alu_src,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic [1:0]      mem_to_reg,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] pc_count,
    input  logic [XLEN-1:0] RD1,
    input  logic [XLEN-1:0] RD2,
    input  logic [XLEN-1:0] signImm,
    output logic            stall,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data,
    output logic            zero,
    output logic [XLEN-1:0] branch_target,
    output logic [4:0]      rd_out,
    output logic            reg_write_out,
    output logic            mem_write_out,
    output logic [1:0]      mem_to_reg_out
);

    exec_state_e     state;
    exec_state_e     state_next;
    alu_op_e         alu_op;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_value;
    logic            is_mul;
    logic            mul_start;
    logic            mul_step;
    logic [4:0]      mul_cnt;
    logic [XLEN-1:0] mul_product;
    logic            res_valid;
    logic [XLEN-1:0] res_value;

    assign alu_op = alu_op_e'(alu_control);
    assign src_b  = alu_src ? signImm : RD2;
    assign is_mul = (alu_op == ALU_MUL);

    always_comb begin
        alu_value = '0;
        case (alu_op)
            ALU_ADD:  alu_value = RD1 + src_b;
            ALU_SUB:  alu_value = RD1 - src_b;
            ALU_AND:  alu_value = RD1 & src_b;
            ALU_OR:   alu_value = RD1 | src_b;
            ALU_XOR:  alu_value = RD1 ^ src_b;
            ALU_SLL:  alu_value = RD1 << src_b[4:0];
            ALU_SRL:  alu_value = RD1 >> src_b[4:0];
            ALU_SRA:  alu_value = $unsigned($signed(RD1) >>> src_b[4:0]);
            ALU_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(RD1) < $signed(src_b))};
            ALU_SLTU: alu_value = {{(XLEN-1){1'b0}}, (RD1 < src_b)};
            default:  alu_value = '0;
        endcase
    end

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .start   (mul_start),
        .step    (mul_step),
        .op_a    (RD1),
        .op_b    (src_b),
        .cnt     (mul_cnt),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush and reset both override whatever the FSM wanted this cycle
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        res_valid  = 1'b0;
        res_value  = '0;
        case (state)
            S_IDLE: begin
                if (valid_in && is_mul) begin
                    stall      = 1'b1;
                    mul_start  = 1'b1;
                    state_next = S_MUL_BUSY;
                end else if (valid_in) begin
                    res_valid = 1'b1;
                    res_value = alu_value;
                end
            end
            S_MUL_BUSY: begin
                mul_step = 1'b1;
                if (mul_cnt == 5'd31) begin
                    res_valid  = 1'b1;
                    res_value  = mul_product;
                    state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush || rst) begin
            state_next = S_IDLE;
            stall      = 1'b0;
            mul_start  = 1'b0;
            mul_step   = 1'b0;
            res_valid  = 1'b0;
            res_value  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !res_valid) begin
            valid_out      <= 1'b0;
            alu_result     <= '0;
            write_data     <= '0;
            zero           <= 1'b0;
            branch_target  <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= '0;
        end else begin
            valid_out      <= 1'b1;
            alu_result     <= res_value;
            write_data     <= RD2;
            zero           <= (res_value == '0);
            branch_target  <= pc_count;
            rd_out         <= rd;
            reg_write_out  <= reg_write;
            mem_write_out  <= mem_write;
            mem_to_reg_out <= mem_to_reg;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, iterative MUL timing, flush and reset.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        flush;
    logic [4:0]  alu_control;
    logic        alu_src;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] pc_count;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] signImm;
    logic        stall;
    logic        valid_out;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        zero;
    logic [31:0] branch_target;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_write_out;
    logic [1:0]  mem_to_reg_out;

    int compared = 0;
    int failed   = 0;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01010;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    execute_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .flush          (flush),
        .alu_control    (alu_control),
        .alu_src        (alu_src),
        .reg_write      (reg_write),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .rd             (rd),
        .pc_count       (pc_count),
        .RD1            (RD1),
        .RD2            (RD2),
        .signImm        (signImm),
        .stall          (stall),
        .valid_out      (valid_out),
        .alu_result     (alu_result),
        .write_data     (write_data),
        .zero           (zero),
        .branch_target  (branch_target),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic src, input logic [31:0] imm,
                                 input logic [4:0] dst, input logic rw, input logic mw,
                                 input logic [1:0] mtr, input logic [31:0] pc);
        valid_in    = v;
        alu_control = op;
        RD1         = a;
        RD2         = b;
        alu_src     = src;
        signImm     = imm;
        rd          = dst;
        reg_write   = rw;
        mem_write   = mw;
        mem_to_reg  = mtr;
        pc_count    = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // register-register op, one edge, compare the result
    task automatic aluCheck(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expected);
        applyStimulus(1'b1, op, a, b, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        checkOutput(tag, alu_result, expected);
    endtask

    task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected, input logic [4:0] dst);
        int stall_cycles;
        int early_valid;
        stall_cycles = 0;
        early_valid  = 0;
        applyStimulus(1'b1, OP_MUL, a, b, 1'b0, 32'h0, dst, 1'b1, 1'b0, 2'b01, 32'h0000_0400);
        for (int e = 1; e <= 33; e++) begin
            if (stall === 1'b1) stall_cycles++;
            tick();
            if (e < 33 && (valid_out !== 1'b0 || alu_result !== 32'h0)) early_valid++;
        end
        checkOutput({tag, "_stall_cycles"}, stall_cycles, 32);
        checkOutput({tag, "_bubbles"}, early_valid, 0);
        checkOutput({tag, "_result"}, alu_result, expected);
        checkOutput({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
        checkOutput({tag, "_rd"}, {27'b0, rd_out}, {27'b0, dst});
        checkOutput({tag, "_mtr"}, {30'b0, mem_to_reg_out}, 32'd1);
    endtask

    initial begin
        int seen_valid;
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b1, OP_MUL, 32'h1234_5678, 32'h9, 1'b0, 32'h0, 5'd9, 1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        tick();
        tick();
        checkOutput("reset_valid", {31'b0, valid_out}, 32'd0);
        checkOutput("reset_result", alu_result, 32'h0);
        checkOutput("reset_misc", {branch_target ^ write_data, rd_out, reg_write_out, mem_write_out, mem_to_reg_out, zero},
                    32'h0);
        rst = 1'b0;

        applyStimulus(1'b1, OP_ADD, 32'd5, 32'h0000_00AA, 1'b1, 32'hFFFF_FFFD, 5'd3, 1'b1, 1'b0, 2'b00, 32'h0000_0100);
        checkOutput("add_stall", {31'b0, stall}, 32'd0);
        tick();
        checkOutput("add_result", alu_result, 32'd2);
        checkOutput("add_zero", {31'b0, zero}, 32'd0);
        checkOutput("add_valid", {31'b0, valid_out}, 32'd1);
        checkOutput("add_target", branch_target, 32'h0000_0100);
        checkOutput("add_wdata", write_data, 32'h0000_00AA);

        applyStimulus(1'b1, OP_SUB, 32'h1234, 32'h1234, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1, 2'b10, 32'h0);
        tick();
        checkOutput("sub_result", alu_result, 32'h0);
        checkOutput("sub_zero", {31'b0, zero}, 32'd1);
        checkOutput("sub_rd", {27'b0, rd_out}, 32'd7);
        checkOutput("sub_rw_mw_mtr", {28'b0, reg_write_out, mem_write_out, mem_to_reg_out}, 32'b1110);

        aluCheck("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        aluCheck("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        aluCheck("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        aluCheck("sll_masked", OP_SLL, 32'h1, 32'h24, 32'h10);
        aluCheck("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        aluCheck("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        aluCheck("slt_signed", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        aluCheck("slt_false", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0);
        aluCheck("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
        aluCheck("sltu_false", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        aluCheck("bad_op", OP_BAD, 32'h1234, 32'h5678, 32'h0);
        checkOutput("bad_op_zero", {31'b0, zero}, 32'd1);

        applyStimulus(1'b0, OP_ADD, 32'd4, 32'd4, 1'b0, 32'h0, 5'd5, 1'b1, 1'b1, 2'b01, 32'h44);
        tick();
        checkOutput("bubble", {valid_out, reg_write_out, mem_write_out, rd_out, alu_result[24:0]}, 32'h0);

        applyStimulus(1'b0, OP_MUL, 32'd4, 32'd4, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 32'h44);
        checkOutput("mul_invalid_stall", {31'b0, stall}, 32'd0);
        tick();

        runMul("mul_ffff", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 5'd12);
        runMul("mul_b2b", 32'd7, 32'd6, 32'd42, 5'd13);

        flush = 1'b1;
        applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0, 2'b00, 32'h0);
        tick();
        checkOutput("flush_idle_bubble", {31'b0, valid_out}, 32'd0);
        flush = 1'b0;

        applyStimulus(1'b1, OP_MUL, 32'h1234, 32'h10, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01, 32'h0);
        repeat (11) tick();
        checkOutput("flush_pre_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush_stall", {31'b0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_bubble", {valid_out, alu_result[30:0]}, 32'h0);
        applyStimulus(1'b0, OP_MUL, 32'h1234, 32'h10, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01, 32'h0);
        seen_valid = 0;
        repeat (40) begin
            tick();
            if (valid_out !== 1'b0) seen_valid++;
        end
        checkOutput("flush_no_product", seen_valid, 0);
        applyStimulus(1'b1, OP_ADD, 32'd2, 32'd3, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0, 2'b00, 32'h0);
        checkOutput("flush_idle_stall", {31'b0, stall}, 32'd0);
        tick();
        checkOutput("flush_then_add", alu_result, 32'd5);

        applyStimulus(1'b1, OP_MUL, 32'd5, 32'd5, 1'b0, 32'h0, 5'd6, 1'b1, 1'b1, 2'b11, 32'h88);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_busy_stall", {31'b0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("rst_busy_outputs", {valid_out, reg_write_out, mem_write_out, mem_to_reg_out, rd_out, alu_result[21:0]},
                    32'h0);
        applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 32'h0);
        checkOutput("rst_add_stall", {31'b0, stall}, 32'd0);
        tick();
        checkOutput("rst_add_result", alu_result, 32'd2);
        applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        seen_valid = 0;
        repeat (40) begin
            tick();
            if (valid_out !== 1'b0) seen_valid++;
        end
        checkOutput("rst_no_product", seen_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
